shift_stream_driver: RTL and testbench
======================================

Name: shift_stream_driver

Overview:
- Upstream feeder for the 4-bit bidirectional serial shift register.
- Accepts parallel words over a valid/ready handshake and serializes them one bit per clock onto the register's `d` input.
- Drives the register's `dir` input for the duration of each word and qualifies each bit with `shift_en`.
- Reports word completion with a one-cycle `done` pulse. Optional idle gap between words.

Parameters:
- WIDTH, 4, bits per word (must be >= 2).
- IDLE_GAP, 0, idle cycles inserted after `done` before the next word can be accepted (0..15).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous reset, active-low.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  parallel word to serialize.
- in_dir  input  1  direction for this word: 1 = LSB first, 0 = MSB first.
- d  output  1  serial bit to the shift register.
- dir  output  1  direction to the shift register, latched per word.
- shift_en  output  1  high on every cycle `d` carries a valid bit.
- busy  output  1  high while in SHIFT or GAP.
- done  output  1  one-cycle pulse after the last bit of a word.

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-low, sampled on the rising edge of `clk`.
  - All outputs are registered.
- Reset values (rst=0 at an edge):
  - state=IDLE, in_ready=1, d=0, dir=0, shift_en=0, busy=0, done=0.
  - Bit counter=0, gap counter=0, shift buffer=0.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, the word is accepted: latch in_data and in_dir, go to SHIFT.
  - Registered outputs after that same edge: shift_en=1, busy=1, in_ready=0, dir=in_dir, counter=0.
  - First bit on `d`: in_data[0] if in_dir=1, in_data[WIDTH-1] if in_dir=0.
- SHIFT:
  - Each edge advances one bit: LSB-first order for dir=1, MSB-first for dir=0.
  - shift_en stays 1 for exactly WIDTH consecutive cycles.
  - At the edge after bit WIDTH-1: shift_en=0, d=0, done=1 for one cycle.
  - Next state is GAP if IDLE_GAP>0, else IDLE with in_ready=1 and busy=0 in the done cycle.
- GAP:
  - in_ready=0, busy=1; counts IDLE_GAP cycles, then IDLE.
  - done is high only in the first GAP cycle.
- Latency: the first bit appears 1 cycle after acceptance.
- Throughput: WIDTH+1+IDLE_GAP cycles per word.
  - Back-to-back with IDLE_GAP=0: the next word is accepted at the edge ending the done cycle.
- Output stability:
  - `dir` changes only at an accept edge and holds its last value while idle.
  - `d` is 0 whenever shift_en=0.
- Handshake: in_valid while in_ready=0 is ignored. The word is neither lost nor latched; upstream must hold it until in_ready=1.
- in_data/in_dir changes during SHIFT do not affect the word in flight.
- Reset mid-word: at the reset edge all state is cleared, the word is discarded, and done is not asserted.
- Reset with in_valid=1: no acceptance on the reset edge.

Test Plan:
- Reset/idle: rst=0 for 5 cycles with in_valid=1 -> in_ready=1, d=0, dir=0, shift_en=0, busy=0, done=0; nothing accepted.
- LSB first: rst=1, in_data=4'b1011, in_dir=1, one-cycle valid -> dir=1; d=1,1,0,1 on 4 consecutive shift_en cycles; then done=1 for 1 cycle; in_ready high again.
- MSB first: in_data=4'b1011, in_dir=0 -> d=1,0,1,1 over 4 shift_en cycles; dir=0 throughout; single done pulse.
- Back-to-back, IDLE_GAP=0: in_valid held high with words 4'hA (dir=1) then 4'h3 (dir=0) -> second accept exactly 5 cycles after the first; d=0,1,0,1 then 0,0,1,1; dir switches only at the second accept.
- Busy/ignore plus gap: IDLE_GAP=2; change in_data to 4'hF mid-word with in_valid=1 -> the in-flight word is unchanged; in_ready stays 0 for the 4 shift cycles plus done plus 1 further gap cycle; 4'hF is accepted afterwards.
- Reset mid-word: assert rst=0 after the 2nd bit -> next cycle shift_en=0, d=0, busy=0, no done; after release, a new word 4'h6 (dir=1) serializes as 0,1,1,0.

Source files
------------

// File: rtl/shift_stream_driver.sv
// Serializes parallel words onto the shift register's d/dir/shift_en inputs.
// All outputs are registered; valid/ready intake, optional idle gap after each word.
module shift_stream_driver #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned IDLE_GAP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  output logic             d,
  output logic             dir,
  output logic             shift_en,
  output logic             busy,
  output logic             done
);

  localparam int unsigned    CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]     GAP_LAST = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [3:0]       gcnt, gcnt_nxt;
  logic [WIDTH-1:0] sbuf, sbuf_nxt;
  logic             in_ready_nxt, d_nxt, dir_nxt, shift_en_nxt, busy_nxt, done_nxt;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    gcnt_nxt     = gcnt;
    sbuf_nxt     = sbuf;
    in_ready_nxt = in_ready;
    d_nxt        = d;
    dir_nxt      = dir;
    shift_en_nxt = shift_en;
    busy_nxt     = busy;
    done_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          // The first bit goes straight to d; the buffer keeps the remaining bits
          // pre-shifted so the next bit always sits at the exit end.
          state_nxt    = SHIFT;
          cnt_nxt      = '0;
          sbuf_nxt     = in_dir ? (in_data >> 1) : (in_data << 1);
          d_nxt        = in_dir ? in_data[0] : in_data[WIDTH-1];
          dir_nxt      = in_dir;
          shift_en_nxt = 1'b1;
          busy_nxt     = 1'b1;
          in_ready_nxt = 1'b0;
        end
      end

      SHIFT: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt      = '0;
          d_nxt        = 1'b0;
          shift_en_nxt = 1'b0;
          done_nxt     = 1'b1;
          if (IDLE_GAP > 0) begin
            state_nxt = GAP;
            gcnt_nxt  = '0;
          end else begin
            state_nxt    = IDLE;
            busy_nxt     = 1'b0;
            in_ready_nxt = 1'b1;
          end
        end else begin
          cnt_nxt  = cnt + 1'b1;
          d_nxt    = dir ? sbuf[0] : sbuf[WIDTH-1];
          sbuf_nxt = dir ? (sbuf >> 1) : (sbuf << 1);
        end
      end

      GAP: begin
        if (gcnt == GAP_LAST) begin
          state_nxt    = IDLE;
          gcnt_nxt     = '0;
          busy_nxt     = 1'b0;
          in_ready_nxt = 1'b1;
        end else begin
          gcnt_nxt = gcnt + 1'b1;
        end
      end

      default: begin
        state_nxt    = IDLE;
        busy_nxt     = 1'b0;
        in_ready_nxt = 1'b1;
        shift_en_nxt = 1'b0;
        d_nxt        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      gcnt     <= '0;
      sbuf     <= '0;
      in_ready <= 1'b1;
      d        <= 1'b0;
      dir      <= 1'b0;
      shift_en <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      gcnt     <= gcnt_nxt;
      sbuf     <= sbuf_nxt;
      in_ready <= in_ready_nxt;
      d        <= d_nxt;
      dir      <= dir_nxt;
      shift_en <= shift_en_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_shift_stream_driver.sv
// Two drivers (IDLE_GAP 0 and 2) share stimulus; a timeline model predicts every output each cycle.
module tb_shift_stream_driver;
  localparam int W  = 4;
  localparam int G0 = 0;
  localparam int G2 = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_dir = 1'b0;
  logic [W-1:0] in_data = '0;

  logic r0, d0, dir0, se0, b0, dn0;
  logic r2, d2, dir2, se2, b2, dn2;
  logic [5:0] v0, v2;
  assign v0 = {r0, d0, dir0, se0, b0, dn0};
  assign v2 = {r2, d2, dir2, se2, b2, dn2};

  shift_stream_driver #(.WIDTH(W), .IDLE_GAP(G0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0), .in_data(in_data),
    .in_dir(in_dir), .d(d0), .dir(dir0), .shift_en(se0), .busy(b0), .done(dn0)
  );

  shift_stream_driver #(.WIDTH(W), .IDLE_GAP(G2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r2), .in_data(in_data),
    .in_dir(in_dir), .d(d2), .dir(dir2), .shift_en(se2), .busy(b2), .done(dn2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit armed = 1'b0;

  // Model: t counts edges since the accept edge; bit k of the word appears at t=k,
  // done at t=W, and the driver is busy while t < W + gap.
  bit           m_act [2];
  int           m_t   [2];
  logic [W-1:0] m_word[2];
  logic         m_wdir[2];
  logic         m_dir [2];

  function automatic logic [5:0] model_vec(int i);
    int   g;
    logic bsy, se, dd, dn;
    g   = (i == 0) ? G0 : G2;
    bsy = m_act[i] && (m_t[i] < W + g);
    se  = m_act[i] && (m_t[i] < W);
    dd  = se ? (m_wdir[i] ? m_word[i][m_t[i]] : m_word[i][W-1-m_t[i]]) : 1'b0;
    dn  = m_act[i] && (m_t[i] == W);
    return {!bsy, dd, m_dir[i], se, bsy, dn};
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst) armed = 1'b1;
    for (int i = 0; i < 2; i++) begin
      automatic int g = (i == 0) ? G0 : G2;
      automatic bit pre_ready = !(m_act[i] && (m_t[i] < W + g));
      if (!rst) begin
        m_act[i] = 1'b0;
        m_t[i]   = 0;
        m_dir[i] = 1'b0;
      end else begin
        if (m_act[i] && m_t[i] < 100) m_t[i]++;
        if (pre_ready && in_valid) begin
          m_act[i]  = 1'b1;
          m_t[i]    = 0;
          m_word[i] = in_data;
          m_wdir[i] = in_dir;
          m_dir[i]  = in_dir;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  logic [31:0] cap0, cap2;
  int n0, n2, nd0, nd2;
  int acc0[$];

  task automatic clear_caps();
    cap0 = '0; cap2 = '0; n0 = 0; n2 = 0; nd0 = 0; nd2 = 0;
    acc0.delete();
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("outputs_gap0", {26'd0, v0}, {26'd0, model_vec(0)});
      chk("outputs_gap2", {26'd0, v2}, {26'd0, model_vec(1)});
      if (se0) begin cap0 = {cap0[30:0], d0}; n0++; end
      if (se2) begin cap2 = {cap2[30:0], d2}; n2++; end
      if (dn0) nd0++;
      if (dn2) nd2++;
      if (rst && in_valid && r0) acc0.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [W-1:0] data, input logic dr);
    in_data  = data;
    in_dir   = dr;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int nr;
    bit switched;
    clear_caps();

    // Reset with valid held high: nothing may be accepted.
    in_valid = 1'b1;
    in_data  = 4'hC;
    repeat (5) step();
    chk("reset_gap0", {26'd0, v0}, 32'b100000);
    chk("reset_gap2", {26'd0, v2}, 32'b100000);
    chk("reset_no_shift", n0 + n2, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    step();

    // LSB first.
    clear_caps();
    send_one(4'b1011, 1'b1);
    repeat (8) step();
    chk("lsb_bits", cap0, 32'b1101);
    chk("lsb_count", n0, 4);
    chk("lsb_done", nd0, 1);
    chk("lsb_ready", {31'd0, r0}, 1);

    // MSB first.
    clear_caps();
    send_one(4'b1011, 1'b0);
    repeat (8) step();
    chk("msb_bits", cap0, 32'b1011);
    chk("msb_done", nd0, 1);
    chk("msb_dir", {31'd0, dir0}, 0);

    // Back-to-back with valid held high.
    clear_caps();
    in_data  = 4'hA;
    in_dir   = 1'b1;
    in_valid = 1'b1;
    switched = 1'b0;
    for (int k = 0; k < 20 && acc0.size() < 2; k++) begin
      step();
      if (acc0.size() == 1 && !switched) begin
        in_data  = 4'h3;
        in_dir   = 1'b0;
        switched = 1'b1;
      end
    end
    in_valid = 1'b0;
    chk("b2b_accepts", acc0.size(), 2);
    if (acc0.size() == 2) chk("b2b_spacing", acc0[1] - acc0[0], 5);
    repeat (8) step();
    chk("b2b_bits", cap0, 32'b01010011);
    chk("b2b_count", n0, 8);
    chk("b2b_done", nd0, 2);

    // Gap plus ignored data change while busy.
    clear_caps();
    in_data  = 4'h5;
    in_dir   = 1'b1;
    in_valid = 1'b1;
    step();
    in_data = 4'hF;
    nr = 0;
    while (!r2 && nr < 30) begin
      nr++;
      step();
    end
    chk("gap_not_ready", nr, 6);
    step();
    in_valid = 1'b0;
    repeat (10) step();
    chk("gap_bits", cap2, 32'b10101111);
    chk("gap_count", n2, 8);
    chk("gap_done", nd2, 2);

    // Reset in the middle of a word.
    clear_caps();
    send_one(4'h9, 1'b1);
    step();
    rst = 1'b0;
    step();
    chk("midrst_gap0", {26'd0, v0}, 32'b100000);
    chk("midrst_gap2", {26'd0, v2}, 32'b100000);
    rst = 1'b1;
    repeat (4) step();
    chk("midrst_no_done", nd0 + nd2, 0);
    chk("midrst_bits", cap0, 32'b10);
    clear_caps();
    send_one(4'h6, 1'b1);
    repeat (8) step();
    chk("after_rst_bits", cap0, 32'b0110);
    chk("after_rst_done", nd0, 1);

    // Randomized traffic, checked every cycle against the model.
    for (int k = 0; k < 600; k++) begin
      rst      = ($urandom_range(0, 59) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = W'($urandom);
      in_dir   = 1'($urandom);
      step();
    end
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
